// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MIPS-style multiply/divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes.
module muldiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = ITER > 1 ? $clog2(ITER) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [1:0] op_r;
    logic [31:0] a_r, b_r, mb, acc, qr;
    logic [32:0] sum, sh;
    logic ge, sa, sb;
    logic [31:0] acc_n, q_n, res_hi, res_lo;
    logic [63:0] mp;
    // acc is the running upper product / partial remainder; qr is multiplier / quotient bits
    always_comb begin
        sa = ~op_r[0] & a_r[31];
        sb = ~op_r[0] & b_r[31];
        sum = {1'b0, acc} + (qr[0] ? {1'b0, mb} : 33'd0);
        sh = {acc, qr[31]};
        ge = sh >= {1'b0, mb};
        acc_n = op_r[1] ? (ge ? sh[31:0] - mb : sh[31:0]) : sum[32:1];
        q_n = op_r[1] ? {qr[30:0], ge} : {sum[0], qr[31:1]};
        mp = (sa ^ sb) ? -{acc_n, q_n} : {acc_n, q_n};
        res_hi = op_r[1] ? (b_r == '0 ? a_r : sa ? -acc_n : acc_n) : mp[63:32];
        res_lo = op_r[1] ? (b_r == '0 ? '1 : (sa ^ sb) ? -q_n : q_n) : mp[31:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            hi <= '0;
            lo <= '0;
            op_r <= '0;
            a_r <= '0;
            b_r <= '0;
            mb <= '0;
            acc <= '0;
            qr <= '0;
        end else if (state == IDLE) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
            if (start) begin
                state <= CALC;
                busy <= 1'b1;
                cnt <= CW'(ITER - 1);
                op_r <= op;
                a_r <= a;
                b_r <= b;
                mb <= (~op[0] & b[31]) ? -b : b;
                acc <= '0;
                qr <= (~op[0] & a[31]) ? -a : a;
            end
        end else if (state == CALC) begin
            acc <= acc_n;
            qr <= q_n;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                hi <= res_hi;
                lo <= res_lo;
                state <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            state <= IDLE;
            done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized self-checking bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
    localparam int ITER = 32;
    logic clk = 0, rst = 1, start = 0, wr_hi = 0, wr_lo = 0;
    logic [1:0] op = 0;
    logic [31:0] a = 0, b = 0, wdata = 0;
    logic busy, done;
    logic [31:0] hi, lo;
    int pass_n = 0, total = 0;

    muldiv_ctrl #(.ITER(ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // returns {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (o[1] && y == 0) return {x, 32'hFFFFFFFF};
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return ux * uy;
            2'd2: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: return {x % y, x / y};
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke);
        logic [63:0] e;
        int lat, bcnt;
        e = model(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1;
        @(negedge clk);
        start = 0; lat = 0; bcnt = 0;
        while (!done && lat <= ITER + 4) begin
            if (busy) bcnt++;
            a = $urandom; b = $urandom; op = 2'($urandom);
            start = poke && lat == 3;
            @(negedge clk);
            lat++;
        end
        start = 0;
        total++; if (lat !== ITER) $display("FAIL latency op=%0d: got %0d want %0d", o, lat, ITER); else pass_n++;
        total++; if (bcnt !== ITER) $display("FAIL busy_cycles op=%0d: got %0d want %0d", o, bcnt, ITER); else pass_n++;
        total++; if (hi !== e[63:32]) $display("FAIL hi op=%0d a=%h b=%h: got %h want %h", o, x, y, hi, e[63:32]); else pass_n++;
        total++; if (lo !== e[31:0]) $display("FAIL lo op=%0d a=%h b=%h: got %h want %h", o, x, y, lo, e[31:0]); else pass_n++;
        if (poke) begin
            start = 1;
            @(negedge clk);
            start = 0;
            @(negedge clk);
            total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL start_in_done: busy=%b done=%b want 0 0", busy, done); else pass_n++;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo: got %h %h want 0 0", hi, lo); else pass_n++;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags: got %b %b want 0 0", busy, done); else pass_n++;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_directed();
        run_op(2'd0, 32'hFFFFFFFE, 32'h3, 0);
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) $display("FAIL mult_neg: got %h%h want FFFFFFFFFFFFFFFA", hi, lo); else pass_n++;
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(2'd2, 32'hFFFFFFF9, 32'h2, 0);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        total++; if (lo !== 32'h80000000 || hi !== 32'h0) $display("FAIL div_ovf: got %h %h want 80000000 0", lo, hi); else pass_n++;
        run_op(2'd3, 32'd100, 32'd0, 0);
        run_op(2'd3, 32'd100, 32'd7, 1);
        run_op(2'd2, 32'd7, 32'd0, 0);
        run_op(2'd2, 32'd7, 32'hFFFFFFFE, 0);
    endtask

    task automatic test_random();
        logic [31:0] y;
        for (int i = 0; i < 40; i++) begin
            y = $urandom;
            if (i % 5 == 1) y = $urandom_range(0, 9);
            if (i % 7 == 2) y = 32'hFFFFFFFF - $urandom_range(0, 3);
            run_op(2'($urandom), $urandom, y, i % 6 == 0);
        end
    endtask

    task automatic test_mtx();
        logic [31:0] prev;
        bit bad;
        int n;
        prev = lo;
        @(negedge clk);
        wdata = 32'h12345678; wr_hi = 1;
        @(negedge clk);
        wr_hi = 0;
        total++; if (hi !== 32'h12345678 || lo !== prev) $display("FAIL mthi: got %h %h want 12345678 %h", hi, lo, prev); else pass_n++;
        wdata = 32'hCAFEF00D; wr_lo = 1;
        @(negedge clk);
        wr_lo = 0;
        total++; if (lo !== 32'hCAFEF00D || hi !== 32'h12345678) $display("FAIL mtlo: got %h %h want 12345678 CAFEF00D", hi, lo); else pass_n++;
        op = 2'd1; a = 32'd5; b = 32'd7; start = 1;
        @(negedge clk);
        start = 0; wr_lo = 1; wr_hi = 1; wdata = 32'hDEADBEEF; bad = 0; n = 0;
        while (!done && n <= ITER + 4) begin
            if (lo !== 32'hCAFEF00D || hi !== 32'h12345678) bad = 1;
            @(negedge clk);
            n++;
        end
        wr_lo = 0; wr_hi = 0;
        total++; if (bad) $display("FAIL write_in_calc: hi/lo changed while busy"); else pass_n++;
        total++; if (!done || hi !== 32'h0 || lo !== 32'd35) $display("FAIL mult_after_write: got done=%b %h %h want 1 0 23", done, hi, lo); else pass_n++;
        @(negedge clk);
        op = 2'd3; a = 32'd50; b = 32'd3; start = 1; wr_hi = 1; wdata = 32'hAAAA5555;
        @(negedge clk);
        start = 0; wr_hi = 0; n = 0;
        total++; if (hi !== 32'hAAAA5555 || busy !== 1'b1) $display("FAIL write_with_start: got %h busy=%b want AAAA5555 1", hi, busy); else pass_n++;
        while (!done && n <= ITER + 4) begin
            @(negedge clk);
            n++;
        end
        total++; if (hi !== 32'd2 || lo !== 32'd16) $display("FAIL result_after_write: got %h %h want 2 10", hi, lo); else pass_n++;
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        op = 2'd1; a = 32'd9; b = 32'd9; start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_flags: got %b %b want 0 0", busy, done); else pass_n++;
        total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL abort_hilo: got %h %h want 0 0", hi, lo); else pass_n++;
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (ITER + 4) begin
            @(negedge clk);
            if (done || busy || hi !== 0 || lo !== 0) seen = 1;
        end
        total++; if (seen) $display("FAIL abort_no_done: activity after reset abort"); else pass_n++;
        run_op(2'd0, $urandom, $urandom, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) run_op(2'(i), $urandom, $urandom_range(1, 1000), 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mtx();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end
endmodule
